eeg_wram_seq: RTL and testbench

//  Command sequencer for the 4-bank weight RAM (WRAM). Accepts one descriptor at a time (opcode, bank mask,

---
 rtl/eeg_wram_pkg.sv | 36 +++
 rtl/eeg_wram_agu.sv | 90 +++++++++
 rtl/eeg_wram_seq.sv | 159 +++++++++++++++
 tb/tb_eeg_wram_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_wram_pkg.sv
// Shared definitions for the WRAM command sequencer: default widths, one-hot
// opcodes, FSM state encoding and opcode classification helpers.
package eeg_wram_pkg;

  localparam int DEF_CMD_DW = 6;
  localparam int DEF_NUM_DW = 4;
  localparam int DEF_ADD_AW = 13;
  localparam int DEF_RPT_DW = 4;

  localparam logic [DEF_CMD_DW-1:0] OPC_ITOW = 6'b000010;
  localparam logic [DEF_CMD_DW-1:0] OPC_CONV = 6'b000100;
  localparam logic [DEF_CMD_DW-1:0] OPC_ATOW = 6'b001000;
  localparam logic [DEF_CMD_DW-1:0] OPC_WTOA = 6'b010000;
  localparam logic [DEF_CMD_DW-1:0] OPC_READ = 6'b100000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CFG   = 2'd1,
    S_GEN   = 2'd2,
    S_DRAIN = 2'd3
  } seq_state_e;

  function automatic logic is_read_class(input logic [DEF_CMD_DW-1:0] opc);
    return (opc == OPC_CONV) || (opc == OPC_WTOA) || (opc == OPC_READ);
  endfunction

  function automatic logic is_write_class(input logic [DEF_CMD_DW-1:0] opc);
    return (opc == OPC_ITOW) || (opc == OPC_ATOW);
  endfunction

  // Exact one-hot match only; multi-hot or zero opcodes are rejected.
  function automatic logic is_legal(input logic [DEF_CMD_DW-1:0] opc);
    return is_read_class(opc) || is_write_class(opc);
  endfunction

endpackage

// File: rtl/eeg_wram_agu.sv
// Per-bank read-address generator: streams BAS..BAS+LEN for RPT+1 passes,
// one beat per VLD&RDY, marks LST on the final beat, then idles with fin held.
module eeg_wram_agu
  import eeg_wram_pkg::*;
#(
  parameter int ADD_AW = DEF_ADD_AW,
  parameter int RPT_DW = DEF_RPT_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [ADD_AW-1:0] bas,
  input  logic [ADD_AW-1:0] len,
  input  logic [RPT_DW-1:0] rpt,
  input  logic              add_rdy,
  output logic              add_vld,
  output logic              add_lst,
  output logic [ADD_AW-1:0] add_add,
  output logic              fin
);

  logic [ADD_AW-1:0] add_q, add_d;
  logic [ADD_AW-1:0] off_q, off_d;
  logic [RPT_DW-1:0] pass_q, pass_d;
  logic              vld_q, vld_d;
  logic              lst_q, lst_d;
  logic              done_q, done_d;
  logic              beat;

  assign beat = vld_q && add_rdy;

  always_comb begin
    add_d  = add_q;
    off_d  = off_q;
    pass_d = pass_q;
    vld_d  = vld_q;
    lst_d  = lst_q;
    done_d = done_q;
    if (ld) begin
      add_d  = bas;
      off_d  = '0;
      pass_d = '0;
      vld_d  = 1'b1;
      lst_d  = (len == '0) && (rpt == '0);
      done_d = 1'b0;
    end else if (beat) begin
      if (lst_q) begin
        vld_d  = 1'b0;
        lst_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        if (off_q == len) begin
          off_d  = '0;
          pass_d = pass_q + RPT_DW'(1);
          add_d  = bas;
        end else begin
          off_d = off_q + ADD_AW'(1);
          add_d = add_q + ADD_AW'(1);
        end
        // LST is computed one beat ahead so it is stable alongside its address.
        lst_d = (off_d == len) && (pass_d == rpt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q  <= '0;
      off_q  <= '0;
      pass_q <= '0;
      vld_q  <= 1'b0;
      lst_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      add_q  <= add_d;
      off_q  <= off_d;
      pass_q <= pass_d;
      vld_q  <= vld_d;
      lst_q  <= lst_d;
      done_q <= done_d;
    end
  end

  assign add_vld = vld_q;
  assign add_lst = lst_q;
  assign add_add = add_q;
  // Includes the LST beat itself so the top can leave S_GEN on that same cycle.
  assign fin     = done_q || (beat && lst_q);

endmodule

// File: rtl/eeg_wram_seq.sv
// WRAM command sequencer: latches one descriptor, issues it on CFG_INFO, runs the
// per-bank address streams for read-class opcodes, then waits for WRAM idle.
module eeg_wram_seq
  import eeg_wram_pkg::*;
#(
  parameter int WRAM_CMD_DW = DEF_CMD_DW,
  parameter int WRAM_NUM_DW = DEF_NUM_DW,
  parameter int WRAM_ADD_AW = DEF_ADD_AW,
  parameter int SEQ_RPT_DW  = DEF_RPT_DW
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             CMD_VLD,
  output logic                             CMD_RDY,
  input  logic [WRAM_CMD_DW-1:0]           CMD_OPC,
  input  logic [WRAM_NUM_DW-1:0]           CMD_MSK,
  input  logic [WRAM_ADD_AW-1:0]           CMD_BAS,
  input  logic [WRAM_ADD_AW-1:0]           CMD_LEN,
  input  logic [SEQ_RPT_DW-1:0]            CMD_RPT,
  output logic                             CFG_INFO_VLD,
  input  logic                             CFG_INFO_RDY,
  output logic [WRAM_CMD_DW-1:0]           CFG_INFO_CMD,
  output logic [WRAM_NUM_DW-1:0]           CFG_WRAM_IDX,
  input  logic                             WRAM_IS_IDLE,
  output logic [WRAM_NUM_DW-1:0]           ADD_VLD,
  output logic [WRAM_NUM_DW-1:0]           ADD_LST,
  input  logic [WRAM_NUM_DW-1:0]           ADD_RDY,
  output logic [WRAM_NUM_DW*WRAM_ADD_AW-1:0] ADD_ADD,
  output logic                             SEQ_DONE,
  output logic                             SEQ_ERR
);

  seq_state_e state_q, state_d;

  logic [WRAM_CMD_DW-1:0] opc_q, opc_d;
  logic [WRAM_NUM_DW-1:0] msk_q, msk_d;
  logic [WRAM_ADD_AW-1:0] bas_q, bas_d;
  logic [WRAM_ADD_AW-1:0] len_q, len_d;
  logic [SEQ_RPT_DW-1:0]  rpt_q, rpt_d;

  logic cmd_rdy_q, cmd_rdy_d;
  logic cfg_vld_q, cfg_vld_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [WRAM_NUM_DW-1:0] agu_ld;
  logic [WRAM_NUM_DW-1:0] agu_fin;
  logic                   all_fin;
  logic                   cfg_hs;

  assign cfg_hs  = cfg_vld_q && CFG_INFO_RDY;
  assign agu_ld  = {WRAM_NUM_DW{cfg_hs && is_read_class(opc_q)}} & msk_q;
  // Unmasked banks never start, so they count as finished.
  assign all_fin = &(agu_fin | ~msk_q);

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    msk_d     = msk_q;
    bas_d     = bas_q;
    len_d     = len_q;
    rpt_d     = rpt_q;
    cmd_rdy_d = 1'b0;
    cfg_vld_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_rdy_d = 1'b1;
        if (CMD_VLD && cmd_rdy_q) begin
          opc_d = CMD_OPC;
          msk_d = CMD_MSK;
          bas_d = CMD_BAS;
          len_d = CMD_LEN;
          rpt_d = CMD_RPT;
          if (is_legal(CMD_OPC)) begin
            state_d   = S_CFG;
            cmd_rdy_d = 1'b0;
            cfg_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CFG: begin
        cfg_vld_d = 1'b1;
        if (CFG_INFO_RDY) begin
          cfg_vld_d = 1'b0;
          state_d   = (is_read_class(opc_q) && (msk_q != '0)) ? S_GEN : S_DRAIN;
        end
      end
      S_GEN: begin
        if (all_fin) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // First DRAIN cycle is already one past the last handshake, so IDLE is trustworthy here.
        if (WRAM_IS_IDLE) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          cmd_rdy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      msk_q     <= '0;
      bas_q     <= '0;
      len_q     <= '0;
      rpt_q     <= '0;
      cmd_rdy_q <= 1'b1;
      cfg_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      msk_q     <= msk_d;
      bas_q     <= bas_d;
      len_q     <= len_d;
      rpt_q     <= rpt_d;
      cmd_rdy_q <= cmd_rdy_d;
      cfg_vld_q <= cfg_vld_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  for (genvar gi = 0; gi < WRAM_NUM_DW; gi++) begin : g_agu
    eeg_wram_agu #(
      .ADD_AW (WRAM_ADD_AW),
      .RPT_DW (SEQ_RPT_DW)
    ) u_agu (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (agu_ld[gi]),
      .bas     (bas_q),
      .len     (len_q),
      .rpt     (rpt_q),
      .add_rdy (ADD_RDY[gi]),
      .add_vld (ADD_VLD[gi]),
      .add_lst (ADD_LST[gi]),
      .add_add (ADD_ADD[gi*WRAM_ADD_AW +: WRAM_ADD_AW]),
      .fin     (agu_fin[gi])
    );
  end

  assign CMD_RDY      = cmd_rdy_q;
  assign CFG_INFO_VLD = cfg_vld_q;
  assign CFG_INFO_CMD = opc_q;
  assign CFG_WRAM_IDX = msk_q;
  assign SEQ_DONE     = done_q;
  assign SEQ_ERR      = err_q;

endmodule

// File: tb/tb_eeg_wram_seq.sv
// Directed bench for eeg_wram_seq: table of full commands plus hand sequences
// for write-class drain, illegal opcode, CFG backpressure and mid-stream reset.
module tb_eeg_wram_seq;

  localparam logic [5:0] OP_ITOW = 6'b000010;
  localparam logic [5:0] OP_CONV = 6'b000100;
  localparam logic [5:0] OP_READ = 6'b100000;
  localparam logic [5:0] OP_BAD  = 6'b000011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [5:0]  CMD_OPC;
  logic [3:0]  CMD_MSK;
  logic [12:0] CMD_BAS;
  logic [12:0] CMD_LEN;
  logic [3:0]  CMD_RPT;
  logic        CFG_INFO_VLD;
  logic        CFG_INFO_RDY;
  logic [5:0]  CFG_INFO_CMD;
  logic [3:0]  CFG_WRAM_IDX;
  logic        WRAM_IS_IDLE;
  logic [3:0]  ADD_VLD;
  logic [3:0]  ADD_LST;
  logic [3:0]  ADD_RDY;
  logic [51:0] ADD_ADD;
  logic        SEQ_DONE;
  logic        SEQ_ERR;

  always #5 clk = ~clk;

  eeg_wram_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CMD_VLD      (CMD_VLD),
    .CMD_RDY      (CMD_RDY),
    .CMD_OPC      (CMD_OPC),
    .CMD_MSK      (CMD_MSK),
    .CMD_BAS      (CMD_BAS),
    .CMD_LEN      (CMD_LEN),
    .CMD_RPT      (CMD_RPT),
    .CFG_INFO_VLD (CFG_INFO_VLD),
    .CFG_INFO_RDY (CFG_INFO_RDY),
    .CFG_INFO_CMD (CFG_INFO_CMD),
    .CFG_WRAM_IDX (CFG_WRAM_IDX),
    .WRAM_IS_IDLE (WRAM_IS_IDLE),
    .ADD_VLD      (ADD_VLD),
    .ADD_LST      (ADD_LST),
    .ADD_RDY      (ADD_RDY),
    .ADD_ADD      (ADD_ADD),
    .SEQ_DONE     (SEQ_DONE),
    .SEQ_ERR      (SEQ_ERR)
  );

  typedef struct packed {
    logic [5:0]        opc;
    logic [3:0]        msk;
    logic [12:0]       bas;
    logic [12:0]       len;
    logic [3:0]        rpt;
    logic              rnd;
    logic [3:0]        nb;
    logic [7:0][12:0]  exp_add;
  } vec_t;

  vec_t tv [4];

  int nvec = 0;
  int nerr = 0;

  logic        rnd_rdy = 1'b0;
  logic [12:0] cap_add [4][16];
  logic        cap_lst [4][16];
  int          cap_n [4];
  logic [3:0]  vld_seen;
  int          done_cnt;
  int          err_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [5:0] opc, input logic [3:0] msk, input logic [12:0] bas,
                               input logic [12:0] len, input logic [3:0] rpt, input logic rnd,
                               input logic [3:0] nb, input logic [7:0][12:0] ea);
    vec_t v;
    v.opc = opc; v.msk = msk; v.bas = bas; v.len = len; v.rpt = rpt;
    v.rnd = rnd; v.nb = nb; v.exp_add = ea;
    return v;
  endfunction

  // Per-bank ready: all-ones or a fresh random pattern every cycle.
  initial begin
    ADD_RDY = 4'hF;
    forever begin
      @(posedge clk); #1;
      ADD_RDY = rnd_rdy ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  end

  // Capture handshakes and enforce hold-while-stalled on every bank.
  initial begin : mon
    logic [3:0]  p_vld, p_rdy, p_lst;
    logic [12:0] p_add [4];
    logic        p_ok;
    p_ok = 1'b0; p_vld = '0; p_rdy = '0; p_lst = '0;
    for (int b = 0; b < 4; b++) begin cap_n[b] = 0; p_add[b] = '0; end
    vld_seen = '0; done_cnt = 0; err_cnt = 0;
    forever begin
      @(negedge clk);
      if (CMD_VLD && CMD_RDY) begin
        for (int b = 0; b < 4; b++) cap_n[b] = 0;
        vld_seen = '0; done_cnt = 0; err_cnt = 0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ADD_VLD[b]) vld_seen[b] = 1'b1;
          if (ADD_VLD[b] && ADD_RDY[b] && cap_n[b] < 16) begin
            cap_add[b][cap_n[b]] = ADD_ADD[b*13 +: 13];
            cap_lst[b][cap_n[b]] = ADD_LST[b];
            cap_n[b]++;
          end
        end
        if (SEQ_DONE) done_cnt++;
        if (SEQ_ERR) err_cnt++;
      end
      if (rst_n && p_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (p_vld[b] && !p_rdy[b]) begin
            chk($sformatf("stall_vld_b%0d", b), ADD_VLD[b], 1);
            chk($sformatf("stall_add_b%0d", b), ADD_ADD[b*13 +: 13], p_add[b]);
            chk($sformatf("stall_lst_b%0d", b), ADD_LST[b], p_lst[b]);
          end
        end
      end
      p_ok = rst_n; p_vld = ADD_VLD; p_rdy = ADD_RDY; p_lst = ADD_LST;
      for (int b = 0; b < 4; b++) p_add[b] = ADD_ADD[b*13 +: 13];
    end
  end

  task automatic issue(input logic [5:0] opc, input logic [3:0] msk, input logic [12:0] bas,
                       input logic [12:0] len, input logic [3:0] rpt);
    @(posedge clk); #1;
    CMD_VLD = 1'b1; CMD_OPC = opc; CMD_MSK = msk; CMD_BAS = bas; CMD_LEN = len; CMD_RPT = rpt;
    @(posedge clk); #1;
    CMD_VLD = 1'b0;
  endtask

  // Must be entered at a negedge.
  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (SEQ_DONE !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, SEQ_DONE, 1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, SEQ_DONE, 0);
    chk({nm, "_rdy_back"}, CMD_RDY, 1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    rnd_rdy = v.rnd; CFG_INFO_RDY = 1'b1; WRAM_IS_IDLE = 1'b1;
    issue(v.opc, v.msk, v.bas, v.len, v.rpt);
    @(negedge clk);
    chk({nm, "_cfg_vld"}, CFG_INFO_VLD, 1);
    chk({nm, "_cfg_cmd"}, CFG_INFO_CMD, v.opc);
    chk({nm, "_cfg_idx"}, CFG_WRAM_IDX, v.msk);
    chk({nm, "_cmd_rdy_low"}, CMD_RDY, 0);
    @(negedge clk);
    chk({nm, "_first_vld"}, ADD_VLD, v.msk);
    wait_done(nm);
    rnd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (v.msk[b]) begin
        chk($sformatf("%s_b%0d_beats", nm, b), cap_n[b], v.nb);
        for (int k = 0; k < int'(v.nb) && k < 16; k++) begin
          chk($sformatf("%s_b%0d_add%0d", nm, b, k), cap_add[b][k], v.exp_add[k]);
          chk($sformatf("%s_b%0d_lst%0d", nm, b, k), cap_lst[b][k], (k == int'(v.nb) - 1));
        end
      end else begin
        chk($sformatf("%s_b%0d_quiet", nm, b), vld_seen[b], 0);
      end
    end
    chk({nm, "_no_err"}, err_cnt, 0);
  endtask

  initial begin
    CMD_VLD = 1'b0; CMD_OPC = '0; CMD_MSK = '0; CMD_BAS = '0; CMD_LEN = '0; CMD_RPT = '0;
    CFG_INFO_RDY = 1'b0; WRAM_IS_IDLE = 1'b1;

    tv[0] = mkv(OP_READ, 4'b1111, 13'd0, 13'd3, 4'd0, 1'b0, 4'd4,
                {13'd0, 13'd0, 13'd0, 13'd0, 13'd3, 13'd2, 13'd1, 13'd0});
    tv[1] = mkv(OP_CONV, 4'b0101, 13'd8190, 13'd3, 4'd1, 1'b0, 4'd8,
                {13'd1, 13'd0, 13'd8191, 13'd8190, 13'd1, 13'd0, 13'd8191, 13'd8190});
    tv[2] = mkv(OP_CONV, 4'b0101, 13'd8190, 13'd3, 4'd1, 1'b1, 4'd8,
                {13'd1, 13'd0, 13'd8191, 13'd8190, 13'd1, 13'd0, 13'd8191, 13'd8190});
    tv[3] = mkv(OP_READ, 4'b1111, 13'd20, 13'd1, 4'd0, 1'b0, 4'd2,
                {13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd21, 13'd20});

    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", CMD_RDY, 1);
    chk("rst_cfg_vld", CFG_INFO_VLD, 0);
    chk("rst_cfg_cmd", CFG_INFO_CMD, 0);
    chk("rst_cfg_idx", CFG_WRAM_IDX, 0);
    chk("rst_add_vld", ADD_VLD, 0);
    chk("rst_add_lst", ADD_LST, 0);
    chk("rst_add_add", ADD_ADD[31:0], 0);
    chk("rst_done", SEQ_DONE, 0);
    chk("rst_err", SEQ_ERR, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_vec(tv[i], $sformatf("v%0d", i));

    // Write class: no address traffic, DONE one cycle after WRAM reports idle.
    WRAM_IS_IDLE = 1'b0; CFG_INFO_RDY = 1'b1;
    issue(OP_ITOW, 4'b0011, 13'd0, 13'd3, 4'd0);
    @(negedge clk);
    chk("itow_cfg_vld", CFG_INFO_VLD, 1);
    chk("itow_cfg_cmd", CFG_INFO_CMD, 6'b000010);
    chk("itow_cfg_idx", CFG_WRAM_IDX, 4'b0011);
    repeat (6) @(negedge clk);
    chk("itow_no_early_done", done_cnt, 0);
    chk("itow_no_add", vld_seen, 0);
    @(posedge clk); #1;
    WRAM_IS_IDLE = 1'b1;
    @(negedge clk);
    chk("itow_done_not_yet", SEQ_DONE, 0);
    @(negedge clk);
    chk("itow_done_1cyc", SEQ_DONE, 1);
    @(negedge clk);
    chk("itow_done_pulse", SEQ_DONE, 0);
    chk("itow_rdy_back", CMD_RDY, 1);

    // Illegal opcode: error pulse only, sequencer stays ready.
    issue(OP_BAD, 4'b1111, 13'd0, 13'd0, 4'd0);
    @(negedge clk);
    chk("bad_err", SEQ_ERR, 1);
    chk("bad_no_cfg", CFG_INFO_VLD, 0);
    chk("bad_cmd_rdy", CMD_RDY, 1);
    @(negedge clk);
    chk("bad_err_pulse", SEQ_ERR, 0);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_still_no_cfg", CFG_INFO_VLD, 0);

    // CFG backpressure: descriptor held for 5 cycles, then single-beat stream.
    CFG_INFO_RDY = 1'b0;
    issue(OP_READ, 4'b0001, 13'd5, 13'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_vld_%0d", i), CFG_INFO_VLD, 1);
      chk($sformatf("hold_cmd_%0d", i), CFG_INFO_CMD, OP_READ);
      chk($sformatf("hold_idx_%0d", i), CFG_WRAM_IDX, 4'b0001);
      chk($sformatf("hold_no_add_%0d", i), ADD_VLD, 0);
    end
    @(posedge clk); #1;
    CFG_INFO_RDY = 1'b1;
    @(negedge clk);
    wait_done("hold");
    chk("hold_beats", cap_n[0], 1);
    chk("hold_add", cap_add[0][0], 5);
    chk("hold_lst", cap_lst[0][0], 1);
    chk("hold_quiet_b1", vld_seen[1], 0);

    // Reset after two beats of a long stream, then a clean restart.
    issue(OP_READ, 4'b1111, 13'd100, 13'd7, 4'd0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_beats", cap_n[0], 2);
    chk("mid_add1", cap_add[0][1], 101);
    chk("mid_lst1", cap_lst[0][1], 0);
    chk("mid_rst_vld", ADD_VLD, 0);
    chk("mid_rst_lst", ADD_LST, 0);
    chk("mid_rst_add", ADD_ADD[31:0], 0);
    chk("mid_rst_cmd_rdy", CMD_RDY, 1);
    chk("mid_rst_cfg_cmd", CFG_INFO_CMD, 0);
    chk("mid_rst_done", SEQ_DONE, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(tv[3], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
